// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor, LSB first, with parallel result capture.
// Optional signed-overflow detection is enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   input  logic             in_valid,
   input  logic             a,
   input  logic             b,
   output logic             s,
   output logic             s_valid,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic            mode_q;
   logic            carry;
   logic [CW-1:0]   cnt;
   logic            bx;
   logic            bit_x;
   logic            carry_nxt;
   logic            last;

   // Subtraction is A + ~B + 1: B is inverted here and the +1 comes from the carry preload.
   always_comb begin
      bx        = b ^ mode_q;
      bit_x     = a ^ bx ^ carry;
      carry_nxt = (a & bx) | (a & carry) | (bx & carry);
      last      = (cnt == CW'(WIDTH - 1));
   end

`ifdef SERIAL_ADDSUB_OVF_EN
   logic msb_cin;
`else
   assign ovf = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         mode_q  <= 1'b0;
         carry   <= 1'b0;
         cnt     <= '0;
         s       <= 1'b0;
         s_valid <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
         ovf     <= 1'b0;
         msb_cin <= 1'b0;
`endif
      end else begin
         s_valid <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state  <= RUN;
                  busy   <= 1'b1;
                  mode_q <= mode;
                  cnt    <= '0;
                  carry  <= mode;
                  sum    <= '0;
                  cout   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
                  ovf     <= 1'b0;
                  msb_cin <= 1'b0;
`endif
               end
            end
            RUN: begin
               if (in_valid) begin
                  s       <= bit_x;
                  s_valid <= 1'b1;
                  sum     <= {bit_x, sum[WIDTH-1:1]};
                  carry   <= carry_nxt;
                  cnt     <= cnt + 1'b1;
`ifdef SERIAL_ADDSUB_OVF_EN
                  // Carry leaving bit WIDTH-2 is the carry into the MSB.
                  if (cnt == CW'(WIDTH - 2))
                     msb_cin <= carry_nxt;
`endif
                  if (last) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     cout  <= carry_nxt;
`ifdef SERIAL_ADDSUB_OVF_EN
                     ovf   <= msb_cin ^ carry_nxt;
`endif
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub (WIDTH=8): stimulus pushes expected bits/results,
// a negedge monitor pops and compares on s_valid and done.
module tb_serial_addsub;

   logic       clk = 1'b0;
   logic       reset, start, mode, in_valid, a, b;
   logic       s, s_valid, busy, done, cout, ovf;
   logic [7:0] sum;

   typedef struct {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } res_t;

   logic exp_s[$];
   res_t exp_r[$];
   int   npass  = 0;
   int   ntotal = 0;
   int   mcnt   = 0;

   serial_addsub #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .in_valid(in_valid),
      .a(a), .b(b), .s(s), .s_valid(s_valid), .busy(busy), .done(done),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_s"},       s,       0);
      chk({tag, "_s_valid"}, s_valid, 0);
      chk({tag, "_busy"},    busy,    0);
      chk({tag, "_done"},    done,    0);
      chk({tag, "_sum"},     sum,     0);
      chk({tag, "_cout"},    cout,    0);
      chk({tag, "_ovf"},     ovf,     0);
   endtask

   // Independent 9-bit arithmetic model of A+B / A-B.
   task automatic model(input logic [7:0] av, input logic [7:0] bv, input logic m,
                        output logic [8:0] r, output logic ov);
      logic [7:0] bb;
      bb = m ? ~bv : bv;
      r  = {1'b0, av} + {1'b0, bb} + {8'd0, m};
`ifdef SERIAL_ADDSUB_OVF_EN
      ov = (av[7] == bb[7]) && (r[7] != av[7]);
`else
      ov = 1'b0;
`endif
   endtask

   task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic m,
                         input int stall_at, input int stall_len,
                         input bit start_mid, input bit start_done);
      logic [8:0] r;
      logic       ov;
      res_t       e;
      model(av, bv, m, r, ov);
      for (int i = 0; i < 8; i++) exp_s.push_back(r[i]);
      e.sum = r[7:0]; e.cout = r[8]; e.ovf = ov;
      exp_r.push_back(e);

      start = 1'b1; mode = m;
      tick();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("sum_cleared_at_start", sum, 0);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; a = av[i]; b = bv[i];
         start = (start_mid && i == 2);
         tick();
         start = 1'b0;
         if (i == stall_at) begin
            in_valid = 1'b0; a = ~a; b = ~b;
            for (int k = 0; k < stall_len; k++) begin
               tick();
               chk("busy_in_stall", busy, 1);
            end
         end
      end
      in_valid = 1'b0;
      chk("done_pulse", done, 1);
      start = start_done;
      tick();
      start = 1'b0;
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
      tick();
      chk("no_restart", busy, 0);
      chk("sum_held", sum, r[7:0]);
      chk("cout_held", cout, r[8]);
   endtask

   always @(negedge clk) begin
      if (s_valid === 1'b1) begin
         if (exp_s.size() == 0) begin
            ntotal++;
            $display("FAIL unexpected_s_valid: got s_valid=1 required s_valid=0");
         end else begin
            chk("s_bit", s, exp_s.pop_front());
         end
         mcnt++;
      end
      if (done === 1'b1) begin
         chk("done_at_last_bit", mcnt, 8);
         if (exp_r.size() == 0) begin
            ntotal++;
            $display("FAIL unexpected_done: got done=1 required done=0");
         end else begin
            res_t e;
            e = exp_r.pop_front();
            chk("sum", sum, e.sum);
            chk("cout", cout, e.cout);
            chk("ovf", ovf, e.ovf);
         end
         mcnt = 0;
      end
      if (reset === 1'b1) mcnt = 0;
   end

   initial begin
      logic [8:0] r;
      logic       ov;
      reset = 1'b1; start = 1'b0; mode = 1'b0; in_valid = 1'b0; a = 1'b0; b = 1'b0;
      repeat (2) tick();
      chk_all_zero("reset");
      reset = 1'b0;
      tick();

      run_op(8'h5A, 8'h3C, 1'b0, -1, 0, 1'b0, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0, -1, 0, 1'b0, 1'b0);
      run_op(8'h10, 8'h01, 1'b1, -1, 0, 1'b0, 1'b0);
      run_op(8'h80, 8'h01, 1'b1, -1, 0, 1'b0, 1'b0);
      run_op(8'h5A, 8'h3C, 1'b0,  3, 3, 1'b0, 1'b0);
      run_op(8'h5A, 8'h3C, 1'b0, -1, 0, 1'b1, 1'b1);

      // Reset after bit 4 of an add: partial result discarded, no done.
      model(8'h5A, 8'h3C, 1'b0, r, ov);
      start = 1'b1; mode = 1'b0;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp_s.push_back(r[i]);
         in_valid = 1'b1; a = r[0] ^ r[0] ^ 1'b0; a = 8'h5A >> i; b = 8'h3C >> i;
         tick();
      end
      in_valid = 1'b0;
      reset = 1'b1;
      tick();
      chk_all_zero("midrun_reset");
      reset = 1'b0;
      in_valid = 1'b1; a = 1'b1; b = 1'b1;
      repeat (2) tick();
      in_valid = 1'b0;
      chk("idle_ignores_in_valid", busy, 0);
      chk("idle_no_s_valid", s_valid, 0);

      run_op(8'h01, 8'h01, 1'b0, -1, 0, 1'b0, 1'b0);

      repeat (3) tick();
      chk("bits_outstanding", exp_s.size(), 0);
      chk("results_outstanding", exp_r.size(), 0);
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
